multiplexador_nx1_reg: RTL and testbench
========================================

Name: multiplexador_nx1_reg

Overview:
- Parametrised N-to-1 multiplexer with a registered output. It is the successor of the combinational 2x1 mux.
- Generalised in data width and channel count.
- Adds per-channel valid/ready handshake, a one-entry output buffer, and two selection modes: fixed external select, or round-robin over requesting channels.
- Sits between several producers and one consumer in the datapath.

Parameters:
- LARGURA, 8, data width per channel in bits (>=1)
- CANAIS, 4, number of input channels (>=2)
- SELW (localparam, derived), $clog2(CANAIS), width of select and channel-ID fields

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- modo  input  1  0 = fixed select (sel), 1 = round-robin
- sel  input  SELW  channel index used when modo=0
- in_dado  input  CANAIS*LARGURA  packed channel data; channel c occupies bits [c*LARGURA +: LARGURA]
- in_valid  input  CANAIS  per-channel data valid
- in_ready  output  CANAIS  per-channel accept, one-hot or zero
- out_dado  output  LARGURA  buffered data
- out_canal  output  SELW  channel index the buffered data came from
- out_valid  output  1  buffer holds data
- out_ready  input  1  consumer accepts out_dado this cycle

Behaviour:
- Reset (async, rst=1): out_valid=0, out_dado=0, out_canal=0, round-robin pointer ptr=0. in_ready is all-zero while rst=1.
- Load condition: pode_carregar = !out_valid || out_ready. This is combinational.
- Grant, modo=0:
  - candidate = sel.
  - If sel >= CANAIS, no grant.
  - Otherwise grant channel sel when in_valid[sel]=1.
- Grant, modo=1: grant the first channel c with in_valid[c]=1, searching ptr, ptr+1, ... modulo CANAIS. No grant if all in_valid are 0.
- in_ready[c] = pode_carregar && (c == granted). At most one bit is set. in_ready may depend combinationally on in_valid, sel, modo and out_ready.
- Transfer in: when in_valid[c] && in_ready[c] at a rising edge:
  - out_dado <= channel c data
  - out_canal <= c
  - out_valid <= 1
- Latency: exactly 1 cycle from input handshake to out_valid.
- Transfer out: when out_valid && out_ready:
  - With a simultaneous load, the buffer is refilled in the same edge (full throughput, one beat per cycle).
  - Without a load, out_valid <= 0.
- Stall: while out_valid && !out_ready, out_dado and out_canal are held stable and in_ready=0. This holds even if sel, modo or in_* change.
- Round-robin pointer:
  - Updates only on an accepted input beat in modo=1: ptr <= (granted==CANAIS-1) ? 0 : granted+1.
  - Unchanged in modo=0.
  - Unchanged on cycles without a grant.
- Mode/sel change: takes effect on the next grant decision (combinational). The buffered beat is never altered.
- Non-power-of-2 CANAIS: ptr wraps at CANAIS-1, never reaching unused indices.
- Reset mid-transfer: the buffered beat is discarded and out_valid drops immediately (async).

Optional Feature:
- Macro: MUX_CONTADOR_EN.
- When defined:
  - Adds output port contagem [15:0], counting beats delivered (out_valid && out_ready).
  - The counter saturates at 16'hFFFF and does not wrap.
  - Reset value is 0.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg: constants MODO_FIXO=1'b0 and MODO_RR=1'b1, plus the counter width constant CONT_W=16.
- One sub-module, arbitro_rr:
  - Parametrised by CANAIS.
  - Inputs: requests and ptr.
  - Outputs: one-hot grant, grant index, and a valid flag.
  - Purely combinational.
- The top holds the buffer, ptr and optional counter.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_dado=0, out_canal=0, in_ready=0 immediately; ptr=0 after release.
- Fixed mode, CANAIS=4, LARGURA=8, modo=0, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; the next cycle gives out_dado=8'hA5, out_canal=2, out_valid=1, and one beat per cycle thereafter.
- Out-of-range select: CANAIS=3, sel=3, in_valid=3'b111 -> in_ready=0 and out_valid stays 0.
- Round-robin fairness: modo=1, all in_valid=1, out_ready=1 for 8 cycles -> out_canal sequence 0,1,2,3,0,1,2,3; with only ch1 and ch3 valid -> 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles while sel and in_dado change -> out_dado and out_canal constant, in_ready=0; out_ready=1 then delivers the beat and loads the next beat in the same edge.
- MUX_CONTADOR_EN: 10 delivered beats -> contagem=10; with the counter forced near 16'hFFFE, 3 more beats -> contagem=16'hFFFF (saturates).

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the registered N-to-1 multiplexer and its arbiter.
package mux_pkg;
    localparam logic MODO_FIXO = 1'b0;
    localparam logic MODO_RR   = 1'b1;
    localparam int   CONT_W    = 16;
endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin arbiter: first requesting channel at or after ptr, modulo CANAIS.
module arbitro_rr #(
    parameter int CANAIS = 4,
    localparam int SELW = $clog2(CANAIS)
) (
    input  logic [CANAIS-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [CANAIS-1:0] gnt,
    output logic [SELW-1:0]   gnt_idx,
    output logic              gnt_valid
);

    always_comb begin
        int c;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        c         = 0;
        for (int i = 0; i < CANAIS; i++) begin
            // ptr never exceeds CANAIS-1, so one subtraction is enough for the wrap
            c = 32'(ptr) + i;
            if (c >= CANAIS) c = c - CANAIS;
            if (!gnt_valid && req[c]) begin
                gnt[c]    = 1'b1;
                gnt_idx   = c[SELW-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplexador_nx1_reg.sv
// Registered N-to-1 mux with valid/ready per channel, fixed or round-robin select.
// Optional beat counter output contagem enabled by defining MUX_CONTADOR_EN.
module multiplexador_nx1_reg
    import mux_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int CANAIS  = 4,
    localparam int SELW   = $clog2(CANAIS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      modo,
    input  logic [SELW-1:0]           sel,
    input  logic [CANAIS*LARGURA-1:0] in_dado,
    input  logic [CANAIS-1:0]         in_valid,
    output logic [CANAIS-1:0]         in_ready,
    output logic [LARGURA-1:0]        out_dado,
    output logic [SELW-1:0]           out_canal,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_CONTADOR_EN
    ,
    output logic [CONT_W-1:0]         contagem
`endif
);

    logic [SELW-1:0]    ptr;
    logic [CANAIS-1:0]  rr_gnt, fix_gnt, gnt;
    logic [SELW-1:0]    rr_idx, gnt_idx;
    logic               rr_valid, gnt_valid;
    logic               pode_carregar, carga;
    logic [LARGURA-1:0] dado_sel;

    arbitro_rr #(.CANAIS(CANAIS)) u_arbitro (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    // An out-of-range sel matches no channel, so it never grants
    always_comb begin
        fix_gnt = '0;
        for (int c = 0; c < CANAIS; c++)
            if (32'(sel) == c) fix_gnt[c] = in_valid[c];
    end

    assign gnt           = (modo == MODO_RR) ? rr_gnt   : fix_gnt;
    assign gnt_idx       = (modo == MODO_RR) ? rr_idx   : sel;
    assign gnt_valid     = (modo == MODO_RR) ? rr_valid : |fix_gnt;
    assign pode_carregar = !out_valid || out_ready;
    assign carga         = pode_carregar && gnt_valid;
    assign in_ready      = (pode_carregar && !rst) ? gnt : '0;

    always_comb begin
        dado_sel = '0;
        for (int c = 0; c < CANAIS; c++)
            if (gnt[c]) dado_sel = in_dado[c*LARGURA +: LARGURA];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dado  <= '0;
            out_canal <= '0;
            ptr       <= '0;
        end else if (carga) begin
            out_dado  <= dado_sel;
            out_canal <= gnt_idx;
            out_valid <= 1'b1;
            if (modo == MODO_RR)
                ptr <= (32'(gnt_idx) == CANAIS-1) ? '0 : gnt_idx + SELW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_CONTADOR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            contagem <= '0;
        else if (out_valid && out_ready && contagem != '1)
            contagem <= contagem + CONT_W'(1);
    end
`endif

endmodule

// File: tb/tb_multiplexador_nx1_reg.sv
// Scoreboard bench for multiplexador_nx1_reg (4-channel main instance, 3-channel side instance).
module tb_multiplexador_nx1_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        modo, out_ready, out_valid;
    logic [1:0]  sel, out_canal;
    logic [31:0] in_dado;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_dado;

    logic        modo3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_canal3;
    logic [23:0] in_dado3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_dado3;

`ifdef MUX_CONTADOR_EN
    logic [15:0] contagem, contagem3;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_deliv = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    multiplexador_nx1_reg #(.LARGURA(8), .CANAIS(4)) dut (
        .clk(clk), .rst(rst), .modo(modo), .sel(sel), .in_dado(in_dado),
        .in_valid(in_valid), .in_ready(in_ready), .out_dado(out_dado),
        .out_canal(out_canal), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_CONTADOR_EN
        , .contagem(contagem)
`endif
    );

    multiplexador_nx1_reg #(.LARGURA(8), .CANAIS(3)) dut3 (
        .clk(clk), .rst(rst), .modo(modo3), .sel(sel3), .in_dado(in_dado3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_dado(out_dado3),
        .out_canal(out_canal3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_CONTADOR_EN
        , .contagem(contagem3)
`endif
    );

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int c, input logic [7:0] d);
        in_dado[c*8 +: 8] = d;
    endtask

    // Monitor: a beat leaves at the next edge whenever out_valid && out_ready
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            n_deliv = 0;
        end else if (out_valid && out_ready) begin
            n_deliv++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected beat: got canal %0d dado %h expected none", out_canal, out_dado);
            end else begin
                e = sb.pop_front();
                chk("beat canal", 32'(out_canal), 32'(e[9:8]));
                chk("beat dado", 32'(out_dado), 32'(e[7:0]));
            end
        end
    end

    int rr_all[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr_odd[4]  = '{1, 3, 1, 3};
    int rr3[5]     = '{0, 1, 2, 0, 1};

    initial begin
        rst = 1'b1; modo = 1'b0; sel = 2'd0; in_dado = '0; in_valid = 4'hF; out_ready = 1'b1;
        modo3 = 1'b0; sel3 = 2'd0; in_dado3 = 24'h332211; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #2;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_dado", 32'(out_dado), 0);
        chk("reset out_canal", 32'(out_canal), 0);
        chk("reset in_ready", 32'(in_ready), 0);
        chk("reset in_ready3", 32'(in_ready3), 0);
        in_valid = '0; in_valid3 = '0;
        step(); step();
        rst = 1'b0;

        // Round-robin, all channels requesting
        modo = 1'b1; in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) setch(c, 8'(i*16 + c));
            #1 chk("rr all in_ready", 32'(in_ready), 32'(1) << rr_all[i]);
            sb.push_back({2'(rr_all[i]), 8'(i*16 + rr_all[i])});
            step();
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) setch(c, 8'(8'h80 + i*16 + c));
            #1 chk("rr odd in_ready", 32'(in_ready), 32'(1) << rr_odd[i]);
            sb.push_back({2'(rr_odd[i]), 8'(8'h80 + i*16 + rr_odd[i])});
            step();
        end
        in_valid = '0;
        step(); step();

        // Fixed select on channel 2
        modo = 1'b0; sel = 2'd2; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            in_dado = '0;
            setch(2, 8'(8'hA5 + i));
            #1 chk("fix in_ready", 32'(in_ready), 32'h4);
            if (i > 0) chk("fix latency dado", 32'(out_dado), 32'(8'hA5 + i - 1));
            sb.push_back({2'd2, 8'(8'hA5 + i)});
            step();
        end
        in_valid = '0;
        step(); step();

        // Backpressure
        out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0010; setch(1, 8'h3C);
        #1 chk("bp load in_ready", 32'(in_ready), 32'h2);
        sb.push_back({2'd1, 8'h3C});
        step();
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            sel = 2'(i);
            in_dado = $urandom;
            #1;
            chk("bp in_ready", 32'(in_ready), 0);
            chk("bp out_dado", 32'(out_dado), 32'h3C);
            chk("bp out_canal", 32'(out_canal), 1);
            chk("bp out_valid", 32'(out_valid), 1);
            step();
        end
        sel = 2'd3; setch(3, 8'h77); out_ready = 1'b1;
        #1 chk("bp release in_ready", 32'(in_ready), 32'h8);
        sb.push_back({2'd3, 8'h77});
        step();
        chk("bp refill dado", 32'(out_dado), 32'h77);
        chk("bp refill canal", 32'(out_canal), 3);
        in_valid = '0;
        step(); step();

        // Reset with a beat held in the buffer
        modo = 1'b1; out_ready = 1'b0; in_valid = 4'b0010; setch(1, 8'h5A);
        step();
        chk("pre-reset out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("midreset out_valid", 32'(out_valid), 0);
        chk("midreset out_dado", 32'(out_dado), 0);
        chk("midreset out_canal", 32'(out_canal), 0);
        chk("midreset in_ready", 32'(in_ready), 0);
        step();
        rst = 1'b0;
        in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) setch(c, 8'(8'hC0 + c));
        #1 chk("post-reset ptr grant", 32'(in_ready), 32'h1);
        sb.push_back({2'd0, 8'hC0});
        step();
        in_valid = '0;
        step(); step();

        // Three-channel instance: out-of-range select, then wrap at CANAIS-1
        sel3 = 2'd3; in_valid3 = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("oor in_ready3", 32'(in_ready3), 0);
            chk("oor out_valid3", 32'(out_valid3), 0);
            step();
        end
        modo3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr3 in_ready", 32'(in_ready3), 32'(1) << rr3[i]);
            step();
            chk("rr3 out_canal", 32'(out_canal3), 32'(rr3[i]));
        end
        in_valid3 = '0;
        step();

`ifdef MUX_CONTADOR_EN
        chk("contagem", 32'(contagem), 32'(n_deliv));
        force dut.contagem = 16'hFFFD;
        step();
        release dut.contagem;
        modo = 1'b0; sel = 2'd0; in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            setch(0, 8'(8'hE0 + i));
            sb.push_back({2'd0, 8'(8'hE0 + i)});
            step();
        end
        in_valid = '0;
        step(); step();
        chk("contagem saturated", 32'(contagem), 32'hFFFF);
`endif

        chk("scoreboard empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
